// File: rtl/npc_lsu.sv
`timescale 1ns/1ps
// npc_lsu: load/store unit bridging the execute stage to a valid/ready memory bus.
// It keeps one access outstanding, with registered outputs throughout.
// It steers byte lanes, builds write strobes, sign/zero-extends loads, and reports
// misalignment, bus errors and response timeouts.
// Ports:
//   i_clk, i_reset_n       clock and asynchronous active-low reset
//   i_req_* / o_req_ready  core request (we, size, unsigned, addr, wdata)
//   o_resp_* / i_resp_ready  core response (rdata, err), held until accepted
//   o_bus_* / i_bus_ready  bus address phase (we, addr, wdata, wstrb)
//   i_bus_rvalid/rdata/rerr  bus data / write-ack phase
module npc_lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_we,
   input  logic [1:0]          i_req_size,
   input  logic                i_req_unsigned,
   input  logic [AW-1:0]       i_req_addr,
   input  logic [XLEN-1:0]     i_req_wdata,
   output logic                o_resp_valid,
   input  logic                i_resp_ready,
   output logic [XLEN-1:0]     o_resp_rdata,
   output logic [1:0]          o_resp_err,
   output logic                o_bus_valid,
   input  logic                i_bus_ready,
   output logic                o_bus_we,
   output logic [AW-1:0]       o_bus_addr,
   output logic [XLEN-1:0]     o_bus_wdata,
   output logic [XLEN/8-1:0]   o_bus_wstrb,
   input  logic                i_bus_rvalid,
   input  logic [XLEN-1:0]     i_bus_rdata,
   input  logic                i_bus_rerr
);

   localparam int unsigned SB   = XLEN / 8;
   localparam int unsigned OB   = $clog2(SB);
   localparam int unsigned TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned TLIM = (TIMEOUT < 2) ? 1 : TIMEOUT - 1;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_BUS      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t              r_state;
   logic                r_req_ready;
   logic                r_resp_valid;
   logic [XLEN-1:0]     r_resp_rdata;
   logic [1:0]          r_resp_err;
   logic                r_bus_valid;
   logic                r_bus_we;
   logic [AW-1:0]       r_bus_addr;
   logic [XLEN-1:0]     r_bus_wdata;
   logic [SB-1:0]       r_bus_wstrb;
   logic [TW-1:0]       r_cnt;
   logic [OB-1:0]       r_offset;
   logic [1:0]          r_size;
   logic                r_unsigned;

   logic [OB-1:0]       w_offset;
   logic [2:0]          w_amask;
   logic [7:0]          w_smask8;
   logic                w_illegal;
   logic [SB-1:0]       w_wstrb;
   logic [XLEN-1:0]     w_wdata;
   logic [AW-1:0]       w_bus_addr;
   logic [XLEN-1:0]     w_lane;
   logic [XLEN-1:0]     w_load;
   logic [TW-1:0]       w_cnt_inc;
   logic                w_expire;

   // Request decode: alignment mask and byte-strobe pattern per access size
   always_comb begin
      w_amask  = 3'b000;
      w_smask8 = 8'h01;
      case (i_req_size)
         2'd0:    begin w_amask = 3'b000; w_smask8 = 8'h01; end
         2'd1:    begin w_amask = 3'b001; w_smask8 = 8'h03; end
         2'd2:    begin w_amask = 3'b011; w_smask8 = 8'h0F; end
         default: begin w_amask = 3'b111; w_smask8 = 8'hFF; end
      endcase
   end

   assign w_offset   = i_req_addr[OB-1:0];
   assign w_illegal  = (|(i_req_addr[2:0] & w_amask)) |
                       ((i_req_size == 2'd3) & (XLEN == 32));
   assign w_wstrb    = i_req_we ? (SB'(w_smask8) << w_offset) : '0;
   assign w_wdata    = i_req_wdata << {w_offset, 3'b000};
   assign w_bus_addr = {i_req_addr[AW-1:OB], OB'(0)};

   // Load path: shift the addressed lane down, then extend to XLEN
   assign w_lane = i_bus_rdata >> {r_offset, 3'b000};

   always_comb begin
      w_load = w_lane;
      case (r_size)
         2'd0:    w_load = r_unsigned ? XLEN'(w_lane[7:0])  : XLEN'($signed(w_lane[7:0]));
         2'd1:    w_load = r_unsigned ? XLEN'(w_lane[15:0]) : XLEN'($signed(w_lane[15:0]));
         2'd2:    w_load = r_unsigned ? XLEN'(w_lane[31:0]) : XLEN'($signed(w_lane[31:0]));
         default: w_load = w_lane;
      endcase
   end

   // The first ADDR cycle counts as cycle 1 after acceptance, so expiry
   // puts resp_valid exactly TIMEOUT cycles after the accepting edge.
   assign w_cnt_inc = r_cnt + TW'(1);
   assign w_expire  = (TIMEOUT != 0) && (w_cnt_inc == TW'(TLIM));

   // Access sequencer with all outputs registered
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= ERR_OK;
         r_bus_valid  <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_bus_wstrb  <= '0;
         r_cnt        <= '0;
         r_offset     <= '0;
         r_size       <= 2'd0;
         r_unsigned   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_req_ready <= 1'b0;
                  r_cnt       <= '0;
                  r_offset    <= w_offset;
                  r_size      <= i_req_size;
                  r_unsigned  <= i_req_unsigned;
                  if (w_illegal) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= ERR_MISALIGN;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state     <= S_ADDR;
                     r_bus_valid <= 1'b1;
                     r_bus_we    <= i_req_we;
                     r_bus_addr  <= w_bus_addr;
                     r_bus_wdata <= w_wdata;
                     r_bus_wstrb <= w_wstrb;
                  end
               end
            end
            S_ADDR: begin
               r_cnt <= w_cnt_inc;
               if (w_expire) begin
                  r_bus_valid  <= 1'b0;
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= ERR_TIMEOUT;
                  r_resp_rdata <= '0;
               end else if (i_bus_ready) begin
                  r_bus_valid <= 1'b0;
                  r_state     <= S_DATA;
               end
            end
            S_DATA: begin
               r_cnt <= w_cnt_inc;
               // A response in the expiry cycle takes priority over the timeout
               if (i_bus_rvalid) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= i_bus_rerr ? ERR_BUS : ERR_OK;
                  r_resp_rdata <= (i_bus_rerr || r_bus_we) ? '0 : w_load;
               end else if (w_expire) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= ERR_TIMEOUT;
                  r_resp_rdata <= '0;
               end
            end
            default: begin
               if (i_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;
   assign o_bus_valid  = r_bus_valid;
   assign o_bus_we     = r_bus_we;
   assign o_bus_addr   = r_bus_addr;
   assign o_bus_wdata  = r_bus_wdata;
   assign o_bus_wstrb  = r_bus_wstrb;

endmodule

// File: tb/tb_npc_lsu.sv
`timescale 1ns/1ps
// tb_npc_lsu: directed and randomized checks of npc_lsu at XLEN=32 and XLEN=64
// (both with TIMEOUT=8). A shared stimulus set is steered to one DUT at a time.
module tb_npc_lsu;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;       // 0: 32-bit DUT, 1: 64-bit DUT

   logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, resp_ready = 1'b0;
   logic        bus_ready = 1'b0, bus_rvalid = 1'b0, bus_rerr = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0, bus_rdata = '0;

   logic        a_req_ready, a_resp_valid, a_bus_valid, a_bus_we;
   logic [31:0] a_resp_rdata, a_bus_addr, a_bus_wdata;
   logic [1:0]  a_resp_err;
   logic [3:0]  a_bus_wstrb;

   logic        b_req_ready, b_resp_valid, b_bus_valid, b_bus_we;
   logic [63:0] b_resp_rdata, b_bus_wdata;
   logic [31:0] b_bus_addr;
   logic [1:0]  b_resp_err;
   logic [7:0]  b_bus_wstrb;

   logic        m_req_ready, m_resp_valid, m_bus_valid, m_bus_we;
   logic [63:0] m_resp_rdata, m_bus_wdata;
   logic [31:0] m_bus_addr;
   logic [1:0]  m_resp_err;
   logic [7:0]  m_bus_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   npc_lsu #(.XLEN(32), .AW(32), .TIMEOUT(T)) u_dut32 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid & ~sel), .o_req_ready(a_req_ready),
      .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_uns),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata[31:0]),
      .o_resp_valid(a_resp_valid), .i_resp_ready(resp_ready & ~sel),
      .o_resp_rdata(a_resp_rdata), .o_resp_err(a_resp_err),
      .o_bus_valid(a_bus_valid), .i_bus_ready(bus_ready & ~sel),
      .o_bus_we(a_bus_we), .o_bus_addr(a_bus_addr), .o_bus_wdata(a_bus_wdata),
      .o_bus_wstrb(a_bus_wstrb), .i_bus_rvalid(bus_rvalid & ~sel),
      .i_bus_rdata(bus_rdata[31:0]), .i_bus_rerr(bus_rerr)
   );

   npc_lsu #(.XLEN(64), .AW(32), .TIMEOUT(T)) u_dut64 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid & sel), .o_req_ready(b_req_ready),
      .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_uns),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(b_resp_valid), .i_resp_ready(resp_ready & sel),
      .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err),
      .o_bus_valid(b_bus_valid), .i_bus_ready(bus_ready & sel),
      .o_bus_we(b_bus_we), .o_bus_addr(b_bus_addr), .o_bus_wdata(b_bus_wdata),
      .o_bus_wstrb(b_bus_wstrb), .i_bus_rvalid(bus_rvalid & sel),
      .i_bus_rdata(bus_rdata), .i_bus_rerr(bus_rerr)
   );

   // Observe whichever DUT is selected, widened to 64-bit data
   always_comb begin
      if (!sel) begin
         m_req_ready  = a_req_ready;   m_resp_valid = a_resp_valid;
         m_resp_rdata = 64'(a_resp_rdata); m_resp_err = a_resp_err;
         m_bus_valid  = a_bus_valid;   m_bus_we     = a_bus_we;
         m_bus_addr   = a_bus_addr;    m_bus_wdata  = 64'(a_bus_wdata);
         m_bus_wstrb  = 8'(a_bus_wstrb);
      end else begin
         m_req_ready  = b_req_ready;   m_resp_valid = b_resp_valid;
         m_resp_rdata = b_resp_rdata;  m_resp_err   = b_resp_err;
         m_bus_valid  = b_bus_valid;   m_bus_we     = b_bus_we;
         m_bus_addr   = b_bus_addr;    m_bus_wdata  = b_bus_wdata;
         m_bus_wstrb  = b_bus_wstrb;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"},  64'(m_req_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(m_resp_valid), 64'd0);
      check({tag, "_resp_rdata"}, m_resp_rdata, 64'd0);
      check({tag, "_resp_err"},   64'(m_resp_err), 64'd0);
      check({tag, "_bus_valid"},  64'(m_bus_valid), 64'd0);
      check({tag, "_bus_we"},     64'(m_bus_we), 64'd0);
      check({tag, "_bus_addr"},   64'(m_bus_addr), 64'd0);
      check({tag, "_bus_wdata"},  m_bus_wdata, 64'd0);
      check({tag, "_bus_wstrb"},  64'(m_bus_wstrb), 64'd0);
   endtask

   function automatic logic [63:0] xmask(input int xlen);
      return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Reference load: gather nbytes from the bus word starting at the byte
   // offset, then extend to XLEN
   function automatic logic [63:0] exp_load(input int xlen, input int size, input bit uns,
                                            input int off, input logic [63:0] word);
      logic [63:0] v;
      int nb;
      nb = 1 << size;
      v  = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!uns && (8*nb < xlen) && v[8*nb-1])
         for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
      return v & xmask(xlen);
   endfunction

   // One access, starting at a negedge with the LSU idle. rw: cycles bus_ready
   // is held low; vw: cycles between address acceptance and rvalid (<0: never);
   // hw: cycles resp_ready is held low. Ends at the negedge after the handshake.
   task automatic run_txn(input bit we, input int size, input bit uns,
                          input logic [31:0] addr, input logic [63:0] wd,
                          input logic [63:0] word, input bit rerr,
                          input int rw, input int vw, input int hw,
                          output logic [63:0] g_rdata, output logic [1:0] g_err,
                          output int g_lat, output logic [63:0] g_wdata,
                          output logic [7:0] g_wstrb);
      int xlen, sb, off, nb, rv, r_cyc;
      bit illegal, done, exp_bv, exp_rv;
      logic [1:0]  e_err;
      logic [63:0] e_rd, e_wd;
      logic [31:0] e_addr;
      logic [7:0]  e_strb;
      xlen    = sel ? 64 : 32;
      sb      = xlen / 8;
      off     = int'(addr % sb);
      nb      = 1 << size;
      illegal = ((addr % nb) != 0) || (size == 3 && xlen == 32);
      rv      = (vw < 0) ? 1000 : 2 + rw + vw;
      r_cyc   = illegal ? 1 : ((rv <= T - 1) ? rv + 1 : T);
      e_err   = illegal ? 2'd1 : (rv > T - 1) ? 2'd3 : rerr ? 2'd2 : 2'd0;
      e_rd    = (e_err == 2'd0 && !we) ? exp_load(xlen, size, uns, off, word) : 64'd0;
      e_addr  = addr - off;
      e_wd    = (wd << (8*off)) & xmask(xlen);
      e_strb  = we ? 8'(((1 << nb) - 1) << off) : 8'd0;
      g_rdata = '0; g_err = '0; g_lat = -1; g_wdata = '0; g_wstrb = '0;
      done    = 1'b0;

      check("idle_req_ready", 64'(m_req_ready), 64'd1);
      req_valid = 1'b1; req_we = we; req_size = 2'(size); req_uns = uns;
      req_addr  = addr; req_wdata = wd;

      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_addr  = $urandom;
         req_wdata = {$urandom, $urandom};
         exp_bv = !illegal && (n <= 1 + rw) && (n < r_cyc);
         exp_rv = (n >= r_cyc) && (n <= r_cyc + hw);
         check("req_ready", 64'(m_req_ready), 64'(n > r_cyc + hw));
         check("bus_valid", 64'(m_bus_valid), 64'(exp_bv));
         check("resp_valid", 64'(m_resp_valid), 64'(exp_rv));
         if (exp_bv) begin
            check("bus_addr",  64'(m_bus_addr), 64'(e_addr));
            check("bus_we",    64'(m_bus_we), 64'(we));
            check("bus_wdata", m_bus_wdata, e_wd);
            check("bus_wstrb", 64'(m_bus_wstrb), 64'(e_strb));
            if (n == 1) begin g_wdata = m_bus_wdata; g_wstrb = m_bus_wstrb; end
         end
         if (exp_rv) begin
            check("resp_rdata", m_resp_rdata, e_rd);
            check("resp_err",   64'(m_resp_err), 64'(e_err));
            if (n == r_cyc) begin
               g_rdata = m_resp_rdata; g_err = m_resp_err;
               g_lat   = m_resp_valid ? n : -1;
            end
         end
         bus_ready  = (n == 1 + rw);
         bus_rvalid = (n == rv);
         bus_rdata  = (n == rv) ? word : {$urandom, $urandom};
         bus_rerr   = (n == rv) ? rerr : 1'($urandom);
         resp_ready = (n == r_cyc + hw);
         if (n == r_cyc + hw + 1) done = 1'b1;
      end
      bus_ready = 1'b0; bus_rvalid = 1'b0; resp_ready = 1'b0;
      check("txn_completed", 64'(done), 64'd1);
   endtask

   logic [63:0] g_rd, g_wd;
   logic [1:0]  g_er;
   logic [7:0]  g_st;
   int          g_lt;

   initial begin
      repeat (2) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // lb sign-extends byte 3 of the bus word; zero-wait latency of 3
      run_txn(0, 0, 0, 32'h8000_0003, 64'd0, 64'h80FF_1234, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("lb_rdata", g_rd, 64'hFFFF_FF80);
      check("lb_err", 64'(g_er), 64'd0);
      check("lb_latency", 64'(g_lt), 64'd3);

      // sh steers to the upper half-word lanes
      run_txn(1, 1, 0, 32'h8000_0002, 64'h0000_BEEF, 64'h1111_2222, 0, 0, 1, 1, g_rd, g_er, g_lt, g_wd, g_st);
      check("sh_wdata", g_wd, 64'hBEEF_0000);
      check("sh_wstrb", 64'(g_st), 64'h0C);
      check("sh_err", 64'(g_er), 64'd0);
      check("sh_rdata", g_rd, 64'd0);

      // misaligned lw and illegal D-size at XLEN=32
      run_txn(0, 2, 0, 32'h8000_0006, 64'd0, 64'd0, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("lw_mis_err", 64'(g_er), 64'd1);
      check("lw_mis_latency", 64'(g_lt), 64'd1);
      run_txn(0, 3, 0, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("ld32_err", 64'(g_er), 64'd1);

      // timeout in DATA, then a stray late rvalid in IDLE
      run_txn(0, 2, 0, 32'h8000_0010, 64'd0, 64'd0, 0, 0, -1, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("tmo_err", 64'(g_er), 64'd3);
      check("tmo_latency", 64'(g_lt), 64'd8);
      bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_BEEF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      check("stray_resp_valid", 64'(m_resp_valid), 64'd0);
      check("stray_req_ready", 64'(m_req_ready), 64'd1);
      check("stray_bus_valid", 64'(m_bus_valid), 64'd0);

      // rvalid in the expiry cycle wins over the timeout
      run_txn(0, 2, 1, 32'h8000_0014, 64'd0, 64'h1234_5678, 0, 3, 2, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("edge_err", 64'(g_er), 64'd0);
      check("edge_rdata", g_rd, 64'h1234_5678);
      check("edge_latency", 64'(g_lt), 64'd8);

      // timeout while bus_ready is still low in ADDR
      run_txn(1, 2, 0, 32'h8000_0018, 64'h5555, 64'd0, 0, 20, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("tmo_addr_err", 64'(g_er), 64'd3);
      check("tmo_addr_latency", 64'(g_lt), 64'd8);

      // stalled address phase, bus error, resp held two cycles
      run_txn(0, 2, 0, 32'h8000_0020, 64'd0, 64'hABCD, 1, 3, 0, 2, g_rd, g_er, g_lt, g_wd, g_st);
      check("buserr_err", 64'(g_er), 64'd2);
      check("buserr_rdata", g_rd, 64'd0);
      check("buserr_latency", 64'(g_lt), 64'd6);

      // reset pulsed while waiting in DATA
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0030;
      @(negedge clk);
      req_valid = 1'b0; bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      check("mid_data_bus_valid", 64'(m_bus_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      check_reset("postrst");
      run_txn(0, 1, 1, 32'h8000_0002, 64'd0, 64'h8765_4321, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("postrst_lhu", g_rd, 64'h8765);

      // XLEN=64 checks
      sel = 1'b1;
      @(negedge clk);
      run_txn(0, 3, 0, 32'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("ld64_rdata", g_rd, 64'h0123_4567_89AB_CDEF);
      run_txn(0, 2, 1, 32'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("lwu64_rdata", g_rd, 64'h0000_0000_DEAD_BEEF);
      run_txn(0, 2, 0, 32'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("lw64_rdata", g_rd, 64'hFFFF_FFFF_DEAD_BEEF);
      run_txn(1, 0, 0, 32'h8000_0007, 64'h00A5, 64'd0, 0, 0, 0, 0, g_rd, g_er, g_lt, g_wd, g_st);
      check("sb64_wstrb", 64'(g_st), 64'h80);
      check("sb64_wdata", g_wd, 64'hA500_0000_0000_0000);

      // randomized accesses on both widths against the reference model
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         @(negedge clk);
         for (int i = 0; i < 40; i++) begin
            int sz;
            logic [31:0] ad;
            sz = int'($urandom_range(0, 3));
            ad = 32'h8000_0000 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ad = ad & ~32'((1 << sz) - 1);
            run_txn(1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom},
                    {$urandom, $urandom}, ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), g_rd, g_er, g_lt, g_wd, g_st);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
